// File: rtl/calc_alu_sequencer.sv
// rtl/calc_alu_sequencer.sv - fixed-point add/sub/mul/div sequencer with shared restoring divider
// Optional rounding in the divider: define CALC_SEQ_ROUND_EN.
module calc_alu_sequencer #(
    parameter int SCALE = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [34:0] a,
    input  logic [24:0] b,
    output logic        busy,
    output logic        done,
    output logic [34:0] result,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, LOAD, MUL, DIV, CHECK, DONE} state_t;

    localparam logic [1:0]  OP_ADD  = 2'd0;
    localparam logic [1:0]  OP_SUB  = 2'd1;
    localparam logic [1:0]  OP_MUL  = 2'd2;
    localparam logic [63:0] SCALE_W = 64'(SCALE);
    localparam logic signed [63:0] MAX_VAL = 64'sd9999000;
    localparam logic signed [63:0] MIN_VAL = -64'sd999000;

    state_t       r_state, w_next;
    logic [1:0]   r_op;
    logic [34:0]  r_a;
    logic [24:0]  r_b;
    logic         r_neg;
    logic [6:0]   r_cnt;
    logic [63:0]  r_mcand;
    logic [24:0]  r_mplier;
    logic [63:0]  r_prod;
    logic [63:0]  r_quo;
    logic [63:0]  r_rem;
    logic [63:0]  r_div;
    logic [63:0]  r_sum;
    logic [34:0]  r_result;
    logic         r_error;

    logic [34:0]  w_abs_a;
    logic [24:0]  w_abs_b;
    logic [63:0]  w_a_ext, w_b_ext;
    logic [63:0]  w_prod_nx;
    logic [64:0]  w_rem_sh;
    logic         w_ge;
    logic [63:0]  w_rem_nx;
    logic [63:0]  w_quo_nx;
    logic         w_round;
    logic [63:0]  w_mag;
    logic [63:0]  w_val;
    logic         w_ovf;

    // Two's-complement negate in the operand width: -2^34 maps to unsigned 2^34.
    assign w_abs_a   = r_a[34] ? (~r_a + 35'd1) : r_a;
    assign w_abs_b   = r_b[24] ? (~r_b + 25'd1) : r_b;
    assign w_a_ext   = {{29{r_a[34]}}, r_a};
    assign w_b_ext   = {{39{r_b[24]}}, r_b};
    assign w_prod_nx = r_prod + (r_mplier[0] ? r_mcand : 64'd0);

    assign w_rem_sh  = {r_rem, r_quo[63]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_nx  = w_ge ? 64'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[63:0];
    assign w_quo_nx  = {r_quo[62:0], w_ge};

`ifdef CALC_SEQ_ROUND_EN
    assign w_round   = ({r_rem, 1'b0} >= {1'b0, r_div});
`else
    assign w_round   = 1'b0;
`endif
    assign w_mag     = r_quo + {63'd0, w_round};
    assign w_val     = r_op[1] ? (r_neg ? (~w_mag + 64'd1) : w_mag) : r_sum;
    assign w_ovf     = ($signed(w_val) > MAX_VAL) || ($signed(w_val) < MIN_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = LOAD;
            LOAD: begin
                case (r_op)
                    OP_ADD, OP_SUB: w_next = CHECK;
                    OP_MUL:         w_next = MUL;
                    default:        w_next = (r_b == 25'd0) ? DONE : DIV;
                endcase
            end
            MUL:   if (r_cnt == 7'd24) w_next = DIV;
            DIV:   if (r_cnt == 7'd63) w_next = CHECK;
            CHECK: w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 2'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_sum    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_op    <= op;
                    r_a     <= a;
                    r_b     <= b;
                    r_error <= 1'b0;
                end
                LOAD: begin
                    r_neg <= r_a[34] ^ r_b[24];
                    r_cnt <= '0;
                    case (r_op)
                        OP_ADD: r_sum <= w_a_ext + w_b_ext;
                        OP_SUB: r_sum <= w_a_ext - w_b_ext;
                        OP_MUL: begin
                            r_mcand  <= {29'd0, w_abs_a};
                            r_mplier <= w_abs_b;
                            r_prod   <= '0;
                        end
                        default: begin
                            if (r_b == 25'd0) begin
                                r_error  <= 1'b1;
                                r_result <= '0;
                            end else begin
                                r_quo <= {29'd0, w_abs_a} * SCALE_W;
                                r_div <= {39'd0, w_abs_b};
                                r_rem <= '0;
                            end
                        end
                    endcase
                end
                MUL: begin
                    // Final product is handed straight to the divider to rescale by SCALE.
                    if (r_cnt == 7'd24) begin
                        r_quo <= w_prod_nx;
                        r_div <= SCALE_W;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                    r_prod   <= w_prod_nx;
                    r_mcand  <= {r_mcand[62:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[24:1]};
                end
                DIV: begin
                    r_quo <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + 7'd1;
                end
                CHECK: begin
                    r_error  <= w_ovf;
                    r_result <= w_ovf ? 35'd0 : w_val[34:0];
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign error  = r_error;
endmodule

// File: tb/tb_calc_alu_sequencer.sv
// tb/tb_calc_alu_sequencer.sv - directed-vector bench for calc_alu_sequencer
module tb_calc_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [34:0] a = '0;
    logic [24:0] b = '0;
    logic        busy, done, error;
    logic [34:0] result;

    int n_checks = 0;
    int n_errors = 0;

    calc_alu_sequencer #(.SCALE(1000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation; glitch>0 pulses an extra start at edge N+glitch,
    // rel=1 releases reset on the same cycle the start is presented.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [34:0] ia,
                          input logic [24:0] ib, input logic [34:0] er, input logic ee,
                          input int elat, input int glitch, input bit rel);
        int lat;
        int nbusy;
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        op = o; a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        nbusy = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (glitch > 0 && k == glitch) begin
                start = 1'b1; op = 2'd0; a = 35'd1; b = 25'd1;
            end
            if (glitch > 0 && k == glitch + 1) start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " busy cycles"}, 64'(nbusy), 64'(elat));
        check({tag, " result"}, {29'd0, result}, {29'd0, er});
        check({tag, " error"}, {63'd0, error}, {63'd0, ee});
        @(negedge clk);
        check({tag, " done pulse end"}, {62'd0, done, busy}, 64'd0);
    endtask

    logic [34:0] div_exp;

    initial begin
`ifdef CALC_SEQ_ROUND_EN
        div_exp = 35'd667;
`else
        div_exp = 35'd666;
`endif
        #12;
        check("reset outputs", {61'd0, busy, done, error, |result}, 64'd0);

        run_op("first after reset ADD", 2'd0, 35'd1500, 25'd2250, 35'd3750, 1'b0, 3, 0, 1'b1);
        run_op("SUB neg", 2'd1, 35'd1000, 25'd3000, -35'sd2000, 1'b0, 3, 0, 1'b0);
        run_op("MUL", 2'd2, 35'd2500, -25'sd4000, -35'sd10000, 1'b0, 92, 0, 1'b0);
        run_op("MUL neg neg", 2'd2, -35'sd1500, -25'sd2000, 35'd3000, 1'b0, 92, 0, 1'b0);
        run_op("DIV", 2'd3, 35'd2000, 25'd3000, div_exp, 1'b0, 67, 0, 1'b0);
        run_op("DIV neg", 2'd3, -35'sd1000, 25'd3000, -35'sd333, 1'b0, 67, 0, 1'b0);
        run_op("DIV by zero", 2'd3, 35'd5000, 25'd0, 35'd0, 1'b1, 2, 0, 1'b0);
        run_op("ADD at max", 2'd0, 35'd9999000, 25'd0, 35'd9999000, 1'b0, 3, 0, 1'b0);
        run_op("ADD overflow", 2'd0, 35'd9999000, 25'd1, 35'd0, 1'b1, 3, 0, 1'b0);
        run_op("SUB underflow", 2'd1, -35'sd999000, 25'd1, 35'd0, 1'b1, 3, 0, 1'b0);
        run_op("DIV min a", 2'd3, 35'h400000000, -25'sd16777215, 35'd1024000, 1'b0, 67, 0, 1'b0);
        run_op("MUL ignores start", 2'd2, 35'd2500, -25'sd4000, -35'sd10000, 1'b0, 92, 10, 1'b0);

        @(negedge clk);
        op = 2'd2; a = 35'd2500; b = -25'sd4000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k < 40; k++) @(negedge clk);
        check("busy mid MUL", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", {61'd0, busy, done, error, |result}, 64'd0);

        run_op("ADD after mid reset", 2'd0, 35'd1500, 25'd2250, 35'd3750, 1'b0, 3, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
